// File: rtl/dsss_pkg.sv
// Shared DSSS definitions: PN sequence parameters, sample/correlation widths
// and despreader state encoding. Imported by the coder and despreader sides.
package dsss_pkg;

    localparam int unsigned PN_LEN    = 31;
    localparam int unsigned PN_W      = 5;
    localparam logic [4:0]  PN_SEED   = 5'b11111;
    // x^5 + x^2 + 1: feedback = lfsr[4] ^ lfsr[1]
    localparam int unsigned PN_TAP_HI = 4;
    localparam int unsigned PN_TAP_LO = 1;

    localparam int unsigned SAMPLE_W  = 3;
    localparam int unsigned CORR_W    = 8;
    localparam int unsigned CNT_W     = 5;

    localparam logic [0:0]  ST_ACQ    = 1'b0;
    localparam logic [0:0]  ST_TRACK  = 1'b1;

    // Magnitude of a signed correlation; -128 never occurs for 31 chips.
    function automatic logic [CORR_W-1:0] corr_abs(input logic signed [CORR_W-1:0] v);
        return v[CORR_W-1] ? CORR_W'(-v) : CORR_W'(v);
    endfunction

endpackage

// File: rtl/pn_gen31.sv
// 31-chip m-sequence generator (Fibonacci LFSR, x^5+x^2+1).
// Ports: clk31 chip clock, rst_n async active-low reset (loads SEED),
//        adv advance one chip this cycle, chip current PN chip (lfsr[4]).
module pn_gen31
    import dsss_pkg::*;
#(
    parameter logic [PN_W-1:0] SEED = PN_SEED
) (
    input  logic clk31,
    input  logic rst_n,
    input  logic adv,
    output logic chip
);

    logic [PN_W-1:0] r_lfsr;
    logic [PN_W-1:0] w_lfsr_nxt;

    // Shift left, feedback enters at bit 0; hold when not advancing.
    always_comb begin
        w_lfsr_nxt = r_lfsr;
        if (adv) begin
            w_lfsr_nxt = {r_lfsr[PN_W-2:0], r_lfsr[PN_TAP_HI] ^ r_lfsr[PN_TAP_LO]};
        end
    end

    always_ff @(posedge clk31 or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= w_lfsr_nxt;
        end
    end

    assign chip = r_lfsr[PN_W-1];

endmodule

// File: rtl/despreader.sv
// DSSS despreader: correlates 31-chip windows of soft samples against the
// local m-sequence, slides one chip per failed window until lock, then
// recovers one data bit per window and drops lock after repeated weak windows.
// Ports: clk31 chip clock, rst_n async active-low reset, rcv_ena receive
//        enable, noised_data 3-bit signed soft chip, out_data recovered bit,
//        out_valid one-cycle bit strobe, locked high in TRACK,
//        corr signed correlation of the last completed window.
module despreader
    import dsss_pkg::*;
#(
    parameter logic [PN_W-1:0] SEED        = PN_SEED,
    parameter int unsigned     ACQ_THRESH  = 40,
    parameter int unsigned     LOSS_THRESH = 24,
    parameter int unsigned     MISS_LIMIT  = 3
) (
    input  logic                clk31,
    input  logic                rst_n,
    input  logic                rcv_ena,
    input  logic [SAMPLE_W-1:0] noised_data,
    output logic                out_data,
    output logic                out_valid,
    output logic                locked,
    output logic [CORR_W-1:0]   corr
);

    localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);

    logic                     w_chip;
    logic                     w_adv;
    logic                     w_last;
    logic signed [CORR_W-1:0] w_samp;
    logic signed [CORR_W-1:0] w_sum;
    logic [CORR_W-1:0]        w_abs;

    logic [0:0]               r_state,  w_state_nxt;
    logic [CNT_W-1:0]         r_cnt,    w_cnt_nxt;
    logic signed [CORR_W-1:0] r_acc,    w_acc_nxt;
    logic signed [CORR_W-1:0] r_corr,   w_corr_nxt;
    logic [MISS_W-1:0]        r_miss,   w_miss_nxt;
    logic                     r_slip,   w_slip_nxt;
    logic                     r_locked, w_locked_nxt;
    logic                     r_valid,  w_valid_nxt;
    logic                     r_data,   w_data_nxt;

    // Local PN holds during a slip cycle and while the receiver is disabled.
    assign w_adv = rcv_ena & ~r_slip;

    pn_gen31 #(.SEED(SEED)) u_pn (
        .clk31 (clk31),
        .rst_n (rst_n),
        .adv   (w_adv),
        .chip  (w_chip)
    );

    // Despread the current sample and form the running window sum.
    assign w_samp = CORR_W'($signed(noised_data));
    assign w_sum  = r_acc + (w_chip ? w_samp : -w_samp);
    assign w_abs  = corr_abs(w_sum);
    assign w_last = (r_cnt == CNT_W'(PN_LEN - 1));

    // Next-state, window-end decisions and output strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_acc_nxt    = r_acc;
        w_corr_nxt   = r_corr;
        w_miss_nxt   = r_miss;
        w_slip_nxt   = 1'b0;
        w_locked_nxt = r_locked;
        w_valid_nxt  = 1'b0;
        w_data_nxt   = r_data;

        if (!rcv_ena) begin
            // Idle: drop any partial window and fall back to acquisition.
            w_state_nxt  = ST_ACQ;
            w_cnt_nxt    = '0;
            w_acc_nxt    = '0;
            w_miss_nxt   = '0;
            w_locked_nxt = 1'b0;
        end else if (r_slip) begin
            // Slip cycle: sample discarded, counter stays at 0.
            w_cnt_nxt = '0;
        end else if (!w_last) begin
            w_acc_nxt = w_sum;
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
            w_acc_nxt  = '0;
            w_cnt_nxt  = '0;
            w_corr_nxt = w_sum;
            if (r_state == ST_ACQ) begin
                if (w_abs >= CORR_W'(ACQ_THRESH)) begin
                    w_state_nxt  = ST_TRACK;
                    w_locked_nxt = 1'b1;
                    w_miss_nxt   = '0;
                end else begin
                    w_slip_nxt = 1'b1;
                end
            end else begin
                w_valid_nxt = 1'b1;
                w_data_nxt  = ~w_sum[CORR_W-1];
                if (w_abs < CORR_W'(LOSS_THRESH)) begin
                    if (r_miss == MISS_W'(MISS_LIMIT - 1)) begin
                        // Lost lock; next window starts immediately, no slip.
                        w_state_nxt  = ST_ACQ;
                        w_locked_nxt = 1'b0;
                        w_miss_nxt   = '0;
                    end else begin
                        w_miss_nxt = r_miss + MISS_W'(1);
                    end
                end else begin
                    w_miss_nxt = '0;
                end
            end
        end
    end

    always_ff @(posedge clk31 or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_ACQ;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_corr   <= '0;
            r_miss   <= '0;
            r_slip   <= 1'b0;
            r_locked <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_acc    <= w_acc_nxt;
            r_corr   <= w_corr_nxt;
            r_miss   <= w_miss_nxt;
            r_slip   <= w_slip_nxt;
            r_locked <= w_locked_nxt;
            r_valid  <= w_valid_nxt;
            r_data   <= w_data_nxt;
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign locked    = r_locked;
    assign corr      = r_corr;

endmodule

// File: tb/tb_despreader.sv
// Directed testbench for despreader: clean lock, inverted data, phase
// acquisition, noise margin, boundary samples, loss of lock, reset and
// rcv_ena drop mid-window.
module tb_despreader;

    logic       clk31;
    logic       rst_n;
    logic       rcv_ena;
    logic [2:0] noised_data;
    logic       out_data;
    logic       out_valid;
    logic       locked;
    logic [7:0] corr;

    int n_tests = 0;
    int n_fail  = 0;
    int tx_idx  = 0;
    logic pn [31];

    despreader dut (
        .clk31       (clk31),
        .rst_n       (rst_n),
        .rcv_ena     (rcv_ena),
        .noised_data (noised_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .locked      (locked),
        .corr        (corr)
    );

    initial clk31 = 1'b0;
    always #5 clk31 = ~clk31;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int corr_s();
        return int'($signed(corr));
    endfunction

    // Drive n chips of the transmit stream delayed by 'delay' chips;
    // chip 1 gets sample hi, chip 0 gets sample lo.
    task automatic drive_chips(input int n, input int hi, input int lo, input int delay);
        int idx;
        for (int i = 0; i < n; i++) begin
            idx = ((tx_idx - delay) % 31 + 31) % 31;
            noised_data = pn[idx] ? 3'(hi) : 3'(lo);
            @(posedge clk31);
            #1;
            tx_idx++;
        end
    endtask

    task automatic do_reset();
        rcv_ena     = 1'b1;
        noised_data = 3'd0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk31);
        #1;
        rst_n  = 1'b1;
        tx_idx = 0;
    endtask

    initial begin
        logic [4:0] l;
        l = 5'b11111;
        for (int i = 0; i < 31; i++) begin
            pn[i] = l[4];
            l = {l[3:0], l[4] ^ l[1]};
        end
        rst_n = 1'b0;
        rcv_ena = 1'b1;
        noised_data = 3'd0;

        // Reset state
        do_reset();
        check_val("rst_corr", corr_s(), 0);
        check_val("rst_locked", int'(locked), 0);
        check_val("rst_valid", int'(out_valid), 0);
        check_val("rst_data", int'(out_data), 0);

        // Clean aligned stimulus, data 1 then data 0
        drive_chips(30, 3, -3, 0);
        check_val("clean_prelock", int'(locked), 0);
        drive_chips(1, 3, -3, 0);
        check_val("clean_lock", int'(locked), 1);
        check_val("clean_corr", corr_s(), 93);
        check_val("clean_lockwin_novalid", int'(out_valid), 0);
        drive_chips(31, 3, -3, 0);
        check_val("clean_valid", int'(out_valid), 1);
        check_val("clean_data", int'(out_data), 1);
        drive_chips(31, -3, 3, 0);
        check_val("inv_corr", corr_s(), -93);
        check_val("inv_valid", int'(out_valid), 1);
        check_val("inv_data", int'(out_data), 0);
        check_val("inv_locked", int'(locked), 1);
        drive_chips(1, 3, -3, 0);
        check_val("strobe_one_cycle", int'(out_valid), 0);

        // Phase offset of 7 chips: exactly 7 slips before lock
        do_reset();
        for (int k = 0; k < 7; k++) begin
            drive_chips(31, 3, -3, 7);
            check_val("ph_nolock", int'(locked), 0);
            if (k == 0) check_val("ph_misalign_corr", corr_s(), -3);
            drive_chips(1, 3, -3, 7);
        end
        drive_chips(31, 3, -3, 7);
        check_val("ph_lock", int'(locked), 1);
        check_val("ph_corr", corr_s(), 93);
        drive_chips(31, 3, -3, 7);
        check_val("ph_valid", int'(out_valid), 1);
        check_val("ph_data", int'(out_data), 1);

        // Noise margin: amplitude 1 must not lock, amplitude 2 must
        do_reset();
        drive_chips(31, 1, -1, 0);
        check_val("amp1_corr", corr_s(), 31);
        check_val("amp1_nolock", int'(locked), 0);
        drive_chips(32, 1, -1, 0);
        check_val("amp1_slip_corr", corr_s(), -1);
        check_val("amp1_nolock2", int'(locked), 0);
        do_reset();
        drive_chips(31, 2, -2, 0);
        check_val("amp2_corr", corr_s(), 62);
        check_val("amp2_lock", int'(locked), 1);

        // Boundary -4 on chip 0, +3 on chip 1
        do_reset();
        drive_chips(31, 3, -4, 0);
        check_val("bnd_corr", corr_s(), 108);
        check_val("bnd_lock", int'(locked), 1);

        // Loss of lock with all-zero samples
        for (int w = 1; w <= 3; w++) begin
            drive_chips(31, 0, 0, 0);
            check_val("loss_valid", int'(out_valid), 1);
            check_val("loss_data", int'(out_data), 1);
            check_val("loss_corr", corr_s(), 0);
            check_val("loss_locked", int'(locked), (w < 3) ? 1 : 0);
        end
        drive_chips(1, 0, 0, 0);
        check_val("loss_after_valid", int'(out_valid), 0);

        // Asynchronous reset at chip 15
        do_reset();
        drive_chips(62, 3, -3, 0);
        drive_chips(15, 3, -3, 0);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_corr", corr_s(), 0);
        check_val("mid_rst_locked", int'(locked), 0);
        check_val("mid_rst_data", int'(out_data), 0);
        check_val("mid_rst_valid", int'(out_valid), 0);
        drive_chips(16, 3, -3, 0);
        check_val("mid_rst_hold_valid", int'(out_valid), 0);
        check_val("mid_rst_hold_corr", corr_s(), 0);

        // rcv_ena dropped on the window-end cycle
        do_reset();
        drive_chips(62, 3, -3, 0);
        check_val("drop_pre_locked", int'(locked), 1);
        drive_chips(30, 3, -3, 0);
        rcv_ena = 1'b0;
        drive_chips(1, 3, -3, 0);
        check_val("drop_valid", int'(out_valid), 0);
        check_val("drop_locked", int'(locked), 0);
        // Local PN held its phase, so resuming on the matching chip relocks.
        rcv_ena = 1'b1;
        tx_idx  = tx_idx - 1;
        drive_chips(31, 3, -3, 0);
        check_val("resume_corr", corr_s(), 93);
        check_val("resume_lock", int'(locked), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
